// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Issue/stall controller between the decode stage and the ID/EX register of
// the five-stage RV64 pipeline. It tracks how many writes are in flight for
// each architectural register and holds decode on RAW (source pending) and
// WAW (destination counter full) hazards. It also sequences multi-cycle
// MUL/DIV/REM operations, squashes IF/ID on taken redirects and halts the
// core on ebreak.
//
// Handshake: decode presents an instruction with id_valid; "issue" acts as
// the ready for that instruction. The instruction moves into ID/EX exactly on
// a cycle where id_valid && issue. While id_valid is high and issue is low,
// decode must hold every id_* input stable. wb_* is a one-cycle
// fire-and-forget retire (no back-pressure). mdu_start/mdu_done form a
// pulse-request / pulse-completion pair.
//
// Ports:
//   sys_clk, sys_rst_n     clock (rising edge), asynchronous active-low reset
//   id_valid               decode holds a valid instruction
//   id_rs1/id_rs2          source register indices
//   id_rs1_used/id_rs2_used  source actually read
//   id_rd, id_wen          destination index, instruction writes rd
//   id_is_mdu              multi-cycle mul/div/rem
//   id_pc_sel              taken branch/jump resolved in decode
//   id_ebreak              ebreak decoded
//   wb_valid, wb_wen, wb_rd  writeback retiring a register write
//   mdu_done               one-cycle MDU completion pulse
//   issue                  decode instruction advances this cycle
//   stall_if, stall_id     hold PC and IF/ID
//   bubble_ex              load NOP into ID/EX
//   flush_if               squash IF/ID contents
//   mdu_start              registered one-cycle MDU start pulse
//   mdu_err                sticky MDU timeout flag
//   halted                 core halted by ebreak
//   stall_cnt              saturating count of stalled decode cycles
//   dbg_state              current controller state (0 RUN, 1 MDU_WAIT, 2 HALT)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_NUM     = 32,
    parameter int CNT_W       = 2,
    parameter int MDU_TIMEOUT = 64,
    parameter int PERF_W      = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [4:0]        id_rd,
    input  logic              id_wen,
    input  logic              id_is_mdu,
    input  logic              id_pc_sel,
    input  logic              id_ebreak,
    input  logic              wb_valid,
    input  logic              wb_wen,
    input  logic [4:0]        wb_rd,
    input  logic              mdu_done,
    output logic              issue,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              flush_if,
    output logic              mdu_start,
    output logic              mdu_err,
    output logic              halted,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = 5;
    // Timeout counter only has to reach MDU_TIMEOUT-1.
    localparam int TO_W  = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MDU_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State and storage
    // -----------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_pend [REG_NUM];
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_mdu_start;
    logic                r_mdu_err;
    logic [PERF_W-1:0]   r_stall_cnt;

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_waw_full;
    logic w_hazard;
    logic w_issue;
    logic w_inc;
    logic w_dec;
    logic w_to_clr;
    logic w_err_set;
    logic w_stalled;

    // A register retiring this very cycle is still read from r_pend, so it
    // still counts as pending: there is no writeback bypass into the hazard
    // check and the stall drops one cycle after the retire.
    assign w_rs1_hit  = id_rs1_used && (id_rs1 != '0) && (r_pend[id_rs1] != '0);
    assign w_rs2_hit  = id_rs2_used && (id_rs2 != '0) && (r_pend[id_rs2] != '0);
    // Block another writer only when its counter could not record it.
    assign w_waw_full = id_wen && (id_rd != '0) && (r_pend[id_rd] == '1);
    assign w_hazard   = w_rs1_hit || w_rs2_hit || w_waw_full;

    assign w_issue    = (r_state == ST_RUN) && id_valid && !w_hazard;

    // Scoreboard events. x0 is filtered out here so its counter never moves;
    // a retire against an empty counter is dropped rather than wrapping.
    assign w_inc      = w_issue && id_wen && (id_rd != '0);
    assign w_dec      = wb_valid && wb_wen && (wb_rd != '0) && (r_pend[wb_rd] != '0);

    assign w_stalled  = id_valid && !w_issue;

    // -----------------------------------------------------------------------
    // Pipeline control outputs
    // -----------------------------------------------------------------------
    assign issue      = w_issue;
    assign stall_id   = w_stalled || (r_state != ST_RUN);
    assign stall_if   = w_stalled || (r_state != ST_RUN);
    assign bubble_ex  = !w_issue;
    // Redirect only squashes when the branch itself actually advances.
    assign flush_if   = w_issue && id_pc_sel;
    assign mdu_start  = r_mdu_start;
    assign mdu_err    = r_mdu_err;
    assign halted     = (r_state == ST_HALT);
    assign stall_cnt  = r_stall_cnt;
    assign dbg_state  = r_state;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_to_clr    = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_RUN: begin
                // mdu_done arriving here is stale and deliberately ignored.
                if (w_issue && id_ebreak) begin
                    w_state_nxt = ST_HALT;
                end else if (w_issue && id_is_mdu) begin
                    w_state_nxt = ST_MDU_WAIT;
                    w_to_clr    = 1'b1;
                end
            end
            ST_MDU_WAIT: begin
                // A done on the last allowed cycle still wins over the timeout.
                if (mdu_done) begin
                    w_state_nxt = ST_RUN;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_err_set   = 1'b1;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // MDU sequencing: start pulse, timeout counter, sticky error
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mdu_start <= 1'b0;
        end else begin
            // High only on the first MDU_WAIT cycle.
            r_mdu_start <= w_to_clr;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_to_cnt <= '0;
        end else if (w_to_clr) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_MDU_WAIT) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mdu_err <= 1'b0;
        end else if (w_err_set) begin
            r_mdu_err <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // In-flight scoreboard
    // -----------------------------------------------------------------------
    // Issue and retire of the same register in one cycle cancel out; on
    // different registers both apply. Writebacks keep draining in any state,
    // including HALT.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (w_inc && (id_rd == IDX_W'(i)) &&
                    !(w_dec && (wb_rd == IDX_W'(i)))) begin
                    r_pend[i] <= r_pend[i] + CNT_W'(1);
                end else if (w_dec && (wb_rd == IDX_W'(i)) &&
                             !(w_inc && (id_rd == IDX_W'(i)))) begin
                    r_pend[i] <= r_pend[i] - CNT_W'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stall performance counter (saturating)
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stalled && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_wen;
  logic        id_is_mdu;
  logic        id_pc_sel;
  logic        id_ebreak;
  logic        wb_valid;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic        mdu_done;
  logic        issue;
  logic        stall_if;
  logic        stall_id;
  logic        bubble_ex;
  logic        flush_if;
  logic        mdu_start;
  logic        mdu_err;
  logic        halted;
  logic [31:0] stall_cnt;
  logic [1:0]  dbg_state;

  int checks;
  int errors;
  int exp_stall;

  pipe_hazard_ctrl #(
    .REG_NUM(32), .CNT_W(2), .MDU_TIMEOUT(64), .PERF_W(32)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wen(id_wen), .id_is_mdu(id_is_mdu),
    .id_pc_sel(id_pc_sel), .id_ebreak(id_ebreak),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .mdu_done(mdu_done),
    .issue(issue), .stall_if(stall_if), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .flush_if(flush_if), .mdu_start(mdu_start),
    .mdu_err(mdu_err), .halted(halted), .stall_cnt(stall_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wen,
                          input logic mdu, input logic pcsel, input logic ebrk);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_wen = wen; id_is_mdu = mdu; id_pc_sel = pcsel; id_ebreak = ebrk;
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] rd);
    wb_valid = v; wb_wen = v; wb_rd = rd;
  endtask

  task automatic idle_inputs();
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_wb(1'b0, 5'd0);
    mdu_done = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    sys_rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    #2;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL rst_issue got=%0b exp=0", issue); end
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL rst_stall_id got=%0b exp=0", stall_id); end
    checks++; if (bubble_ex !== 1'b1) begin errors++; $display("FAIL rst_bubble got=%0b exp=1", bubble_ex); end
    checks++; if (mdu_start !== 1'b0) begin errors++; $display("FAIL rst_mdu_start got=%0b exp=0", mdu_start); end
    checks++; if (mdu_err !== 1'b0) begin errors++; $display("FAIL rst_mdu_err got=%0b exp=0", mdu_err); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got=%0b exp=0", halted); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    drive_id(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 0);
    #2;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL b2b_first_issue got=%0b exp=1", issue); end
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL b2b_first_stall got=%0b exp=0", stall_id); end
    tick();
    drive_id(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0);
    #2;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL b2b_dep_issue got=%0b exp=0", issue); end
    checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL b2b_dep_stall_id got=%0b exp=1", stall_id); end
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL b2b_dep_stall_if got=%0b exp=1", stall_if); end
    checks++; if (bubble_ex !== 1'b1) begin errors++; $display("FAIL b2b_dep_bubble got=%0b exp=1", bubble_ex); end
    exp_stall++;
    tick();
    drive_wb(1, 5'd5);
    #2;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL b2b_retire_same_cycle got=%0b exp=0", issue); end
    exp_stall++;
    tick();
    drive_wb(0, 5'd0);
    #2;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL b2b_after_retire got=%0b exp=1", issue); end
    checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL b2b_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
    tick();
    idle_inputs();
    drive_wb(1, 5'd6);
    tick();
    idle_inputs();
  endtask

  task automatic test_x0_unused();
    drive_id(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0, 0);
    tick();
    for (int n = 0; n < 4; n++) begin
      drive_id(1, 5'd0, 1, 5'd7, 0, 5'd0, 1, 0, 0, 0);
      #2;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL x0_unused_issue n=%0d got=%0b exp=1", n, issue); end
      tick();
    end
    drive_id(1, 5'd0, 1, 5'd7, 1, 5'd0, 0, 0, 0, 0);
    #2;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL x0_rs2_used got=%0b exp=0", issue); end
    exp_stall++;
    tick();
    drive_wb(1, 5'd7);
    #2;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL x0_rs2_retire got=%0b exp=0", issue); end
    exp_stall++;
    tick();
    drive_wb(0, 5'd0);
    #2;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL x0_rs2_release got=%0b exp=1", issue); end
    tick();
    idle_inputs();
    #2;
    checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL x0_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_waw();
    for (int n = 0; n < 3; n++) begin
      drive_id(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 0);
      #2;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_fill n=%0d got=%0b exp=1", n, issue); end
      tick();
    end
    drive_id(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 0);
    #2;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL waw_full got=%0b exp=0", issue); end
    exp_stall++;
    tick();
    drive_wb(1, 5'd3);
    #2;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL waw_full_retire got=%0b exp=0", issue); end
    exp_stall++;
    tick();
    drive_wb(0, 5'd0);
    #2;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_release got=%0b exp=1", issue); end
    tick();
    idle_inputs();
    drive_wb(1, 5'd3);
    tick();
    // counter at 2: issue and retire x3 together must leave it at 2
    drive_id(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 0);
    #2;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_same_cycle_issue got=%0b exp=1", issue); end
    tick();
    drive_wb(0, 5'd0);
    #2;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_after_same_cycle got=%0b exp=1", issue); end
    tick();
    #2;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL waw_full_again got=%0b exp=0", issue); end
    exp_stall++;
    tick();
    idle_inputs();
    for (int n = 0; n < 4; n++) begin
      drive_wb(1, 5'd3);
      tick();
    end
    drive_wb(0, 5'd0);
    drive_id(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 0);
    #2;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_drained_issue got=%0b exp=1", issue); end
    tick();
    drive_id(1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    #2;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL waw_zero_dec_ignored got=%0b exp=0", issue); end
    exp_stall++;
    tick();
    idle_inputs();
    drive_wb(1, 5'd3);
    tick();
    idle_inputs();
    #2;
    checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL waw_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_mdu();
    drive_id(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 0, 0);
    #2;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL mdu_issue got=%0b exp=1", issue); end
    checks++; if (mdu_start !== 1'b0) begin errors++; $display("FAIL mdu_start_early got=%0b exp=0", mdu_start); end
    tick();
    idle_inputs();
    #2;
    checks++; if (mdu_start !== 1'b1) begin errors++; $display("FAIL mdu_start_pulse got=%0b exp=1", mdu_start); end
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL mdu_state_wait got=%0d exp=1", dbg_state); end
    checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL mdu_stall_id got=%0b exp=1", stall_id); end
    checks++; if (bubble_ex !== 1'b1) begin errors++; $display("FAIL mdu_bubble got=%0b exp=1", bubble_ex); end
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      mdu_done = (k == 4);
      #2;
      checks++; if (issue !== 1'b0) begin errors++; $display("FAIL mdu_wait_issue k=%0d got=%0b exp=0", k, issue); end
      checks++; if (mdu_start !== 1'b0) begin errors++; $display("FAIL mdu_start_once k=%0d got=%0b exp=0", k, mdu_start); end
      exp_stall++;
      tick();
    end
    mdu_done = 1'b0;
    #2;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL mdu_resume got=%0b exp=1", issue); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL mdu_state_run got=%0d exp=0", dbg_state); end
    tick();
    idle_inputs();
    mdu_done = 1'b1;
    tick();
    mdu_done = 1'b0;
    drive_wb(1, 5'd8);
    #2;
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL mdu_done_in_run got=%0d exp=0", dbg_state); end
    checks++; if (mdu_err !== 1'b0) begin errors++; $display("FAIL mdu_err_clean got=%0b exp=0", mdu_err); end
    tick();
    idle_inputs();
    #2;
    checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL mdu_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_mdu_timeout();
    drive_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0);
    tick();
    idle_inputs();
    for (int k = 0; k < 64; k++) begin
      #2;
      checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL to_still_waiting k=%0d got=%0d exp=1", k, dbg_state); end
      checks++; if (mdu_err !== 1'b0) begin errors++; $display("FAIL to_err_early k=%0d got=%0b exp=0", k, mdu_err); end
      tick();
    end
    #2;
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL to_back_to_run got=%0d exp=0", dbg_state); end
    checks++; if (mdu_err !== 1'b1) begin errors++; $display("FAIL to_err_set got=%0b exp=1", mdu_err); end
    tick();
    tick();
    checks++; if (mdu_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky got=%0b exp=1", mdu_err); end
  endtask

  task automatic test_redirect_halt();
    drive_id(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 1, 0);
    #2;
    checks++; if (flush_if !== 1'b1) begin errors++; $display("FAIL rd_flush got=%0b exp=1", flush_if); end
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL rd_no_stall got=%0b exp=0", stall_id); end
    tick();
    drive_id(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 1, 0);
    #2;
    checks++; if (flush_if !== 1'b0) begin errors++; $display("FAIL rd_flush_stalled got=%0b exp=0", flush_if); end
    exp_stall++;
    tick();
    idle_inputs();
    drive_wb(1, 5'd9);
    tick();
    idle_inputs();
    drive_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 0);
    #2;
    checks++; if (flush_if !== 1'b1) begin errors++; $display("FAIL rd_mdu_flush got=%0b exp=1", flush_if); end
    tick();
    idle_inputs();
    #2;
    checks++; if (flush_if !== 1'b0) begin errors++; $display("FAIL rd_flush_one_cycle got=%0b exp=0", flush_if); end
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL rd_mdu_state got=%0d exp=1", dbg_state); end
    checks++; if (mdu_start !== 1'b1) begin errors++; $display("FAIL rd_mdu_start got=%0b exp=1", mdu_start); end
    mdu_done = 1'b1;
    tick();
    mdu_done = 1'b0;
    drive_id(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 0, 0, 1);
    #2;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL halt_ebreak_issue got=%0b exp=1", issue); end
    tick();
    idle_inputs();
    #2;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted got=%0b exp=1", halted); end
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL halt_state got=%0d exp=2", dbg_state); end
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL halt_stall_if got=%0b exp=1", stall_if); end
    tick();
    for (int n = 0; n < 3; n++) begin
      drive_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      #2;
      checks++; if (issue !== 1'b0) begin errors++; $display("FAIL halt_no_issue n=%0d got=%0b exp=0", n, issue); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_absorbing n=%0d got=%0b exp=1", n, halted); end
      exp_stall++;
      tick();
    end
    #2;
    checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL halt_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
    sys_rst_n = 1'b0;
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset_halted got=%0b exp=0", halted); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL halt_reset_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (mdu_err !== 1'b0) begin errors++; $display("FAIL halt_reset_mdu_err got=%0b exp=0", mdu_err); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL halt_reset_state got=%0d exp=0", dbg_state); end
    exp_stall = 0;
    idle_inputs();
    tick();
    sys_rst_n = 1'b1;
    tick();
    drive_id(1, 5'd10, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    #2;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL halt_reset_pend_clear got=%0b exp=1", issue); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mdu();
    drive_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0);
    tick();
    idle_inputs();
    #2;
    checks++; if (mdu_start !== 1'b1) begin errors++; $display("FAIL rmdu_start got=%0b exp=1", mdu_start); end
    sys_rst_n = 1'b0;
    #1;
    checks++; if (mdu_start !== 1'b0) begin errors++; $display("FAIL rmdu_start_cleared got=%0b exp=0", mdu_start); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rmdu_state got=%0d exp=0", dbg_state); end
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  // sequencer and final report
  initial begin
    checks = 0;
    errors = 0;
    exp_stall = 0;
    test_reset();
    test_back_to_back();
    test_x0_unused();
    test_waw();
    test_mdu();
    test_mdu_timeout();
    test_redirect_halt();
    test_reset_mdu();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Issue/stall controller for the five-stage RV64 pipeline, sitting between the decode stage and ID/EX.
- Keeps a per-register in-flight scoreboard and stalls decode on RAW/WAW hazards.
- Sequences multi-cycle MUL/DIV/REM operations through a start/done handshake, raises IF flush on taken redirects and halts the core on ebreak.

Parameters:
- REG_NUM, 32, number of architectural integer registers (x0 hard-wired zero).
- CNT_W, 2, width of each per-register in-flight counter (max 2^CNT_W-1 writes in flight).
- MDU_TIMEOUT, 64, cycles waited for mdu_done before abort.
- PERF_W, 32, width of stall performance counter.

Ports:
- sys_clk  in  1  core clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs1, id_rs2  in  5 each  source register indices.
- id_rs1_used, id_rs2_used  in  1 each  source actually read.
- id_rd  in  5  destination index.
- id_wen  in  1  instruction writes rd.
- id_is_mdu  in  1  mul/div/rem (multi-cycle).
- id_pc_sel  in  1  taken branch/jump resolved in decode.
- id_ebreak  in  1  ebreak decoded.
- wb_valid, wb_wen  in  1 each  writeback retiring a register write.
- wb_rd  in  5  retiring destination.
- mdu_done  in  1  one-cycle MDU completion pulse.
- issue  out  1  decode instruction advances into ID/EX this cycle.
- stall_if, stall_id  out  1 each  hold PC and IF/ID.
- bubble_ex  out  1  load NOP into ID/EX.
- flush_if  out  1  squash IF/ID contents.
- mdu_start  out  1  registered one-cycle start pulse.
- mdu_err  out  1  sticky timeout flag.
- halted  out  1  core halted by ebreak.
- stall_cnt  out  PERF_W  saturating count of stalled cycles.

Behaviour:
- States: RUN, MDU_WAIT, HALT. Reset -> RUN, all pend counters 0, every registered output 0.
- Hazard, combinational:
  - src hit = used & idx!=0 & pend[idx]!=0, for rs1 or rs2.
  - waw_full = id_wen & rd!=0 & pend[rd]==all-ones.
  - hazard = src hit | waw_full.
- issue = state==RUN & id_valid & ~hazard.
- Stall and bubble, combinational:
  - stall_id = stall_if = (id_valid & ~issue) | state!=RUN.
  - bubble_ex = ~issue.
- flush_if = issue & id_pc_sel, combinational, same cycle. Redirect has priority over nothing else; no stall on its own.
- Scoreboard update per edge:
  - inc = issue & id_wen & rd!=0; dec = wb_valid & wb_wen & wb_rd!=0 & pend[wb_rd]!=0.
  - Same register with inc and dec -> unchanged. Different registers -> both apply.
  - dec against a zero counter is ignored.
  - x0 is never tracked.
- Writeback visibility: a register retiring in the same cycle still counts as pending. No bypass; the stall releases the following cycle.
- RUN -> MDU_WAIT on issue & id_is_mdu.
  - mdu_start = 1 on the next cycle only.
  - Timeout counter cleared on entry.
- MDU_WAIT: no issue.
  - mdu_done -> RUN; issue is possible on the following cycle.
  - Counter reaches MDU_TIMEOUT-1 without done -> mdu_err set (sticky until reset), then RUN.
  - mdu_done while in RUN is ignored.
- RUN -> HALT on issue & id_ebreak. HALT is absorbing: halted=1, stalls held, bubbles inserted, until reset. Writebacks still decrement the scoreboard.
- Simultaneous id_is_mdu & id_pc_sel: both take effect (flush and MDU_WAIT).
- stall_cnt increments each cycle id_valid & ~issue and saturates at all-ones.
- Reset mid-operation, from any state: clears the scoreboard, FSM and counters asynchronously. mdu_start is deasserted immediately.

Test Plan:
- Back-to-back dependency: issue add x5 (wen), next id rs1=5 used -> issue=0, stall_id=1, bubble_ex=1. wb_rd=5 retires -> issue=1 the cycle after retire; stall_cnt counts the stalled cycles.
- x0 and unused sources: issue wen rd=0, then rs1=0 used and rs2=7 unused with pend[7]=1 -> no stall, pend[0] stays 0.
- WAW saturation, CNT_W=2: three issues writing x3 with no writeback -> fourth write to x3 stalls. One wb_rd=3 -> issues. Same-cycle issue+retire of x3 leaves the counter unchanged.
- MDU handshake: issue with id_is_mdu=1 -> mdu_start=1 next cycle, state MDU_WAIT, stall_id=1. mdu_done at cycle +5 -> issue resumes the cycle after. With mdu_done withheld for 64 cycles -> mdu_err=1, return to RUN.
- Redirect and halt: issue with id_pc_sel=1 -> flush_if=1 the same cycle only. Issue ebreak -> halted=1 and permanent stall. Asserting sys_rst_n=0 mid-HALT -> halted=0, all pend 0, stall_cnt=0 immediately.
